// File: rtl/beam_sum_sequencer.sv
// beam_sum_sequencer: single-adder time-multiplexed sum of N_CH signed channel samples per frame.
module beam_sum_sequencer #(
  parameter int N_CH  = 16,
  parameter int IN_W  = 19,
  parameter int OUT_W = 23,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] ch_idx,
  output logic [OUT_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d, ext;
  logic [CNT_W-1:0] ch_idx_q, ch_idx_d;
  logic out_valid_q, out_valid_d, frame_err_q, frame_err_d, xfer;
  assign ext       = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign in_ready  = state_q != OUTPUT;
  assign xfer      = in_valid && in_ready;
  assign busy      = state_q != IDLE;
  assign ch_idx    = ch_idx_q;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ch_idx_d    = ch_idx_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        if (in_first) begin
          acc_d    = ext;
          ch_idx_d = CNT_W'(1);
          state_d  = ACCUM;
        end else frame_err_d = 1'b1;
      end
      ACCUM: if (xfer) begin
        if (in_first) begin
          // premature frame start: drop the partial sum and restart on this sample
          frame_err_d = 1'b1;
          acc_d       = ext;
          ch_idx_d    = CNT_W'(1);
        end else if (ch_idx_q == CNT_W'(N_CH-1)) begin
          out_sum_d   = acc_q + ext;
          out_valid_d = 1'b1;
          ch_idx_d    = '0;
          state_d     = OUTPUT;
        end else begin
          acc_d    = acc_q + ext;
          ch_idx_d = ch_idx_q + CNT_W'(1);
        end
      end
      OUTPUT: if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ch_idx_q    <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ch_idx_q    <= ch_idx_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_beam_sum_sequencer.sv
// tb_beam_sum_sequencer: randomized stimulus with a frame-level reference model and an output scoreboard.
module tb_beam_sum_sequencer;
  localparam int N_CH = 16, IN_W = 19, OUT_W = 23, CNT_W = 4;
  logic clk = 0, rst_n = 0;
  logic [IN_W-1:0] in_data = '0;
  logic in_first = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, frame_err, busy;
  logic [CNT_W-1:0] ch_idx;
  logic [OUT_W-1:0] out_sum;
  int checks = 0, failures = 0;
  int exp_q[$];
  int m_sum = 0, m_cnt = 0, err_exp = 0, err_seen = 0;
  bit in_frame = 0, rnd_or = 0;
  bit prev_ov = 0, prev_or = 0;
  logic [OUT_W-1:0] prev_sum = '0;

  beam_sum_sequencer #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_first(in_first), .in_valid(in_valid),
    .in_ready(in_ready), .ch_idx(ch_idx), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor: pops on every output handshake and watches hold stability
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (prev_ov && !prev_or && rst_n) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'($signed(out_sum)), int'($signed(prev_sum)));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("out_sum", int'($signed(out_sum)), exp_q.pop_front());
    end
    prev_ov = out_valid; prev_or = out_ready; prev_sum = out_sum;
  end

  always @(posedge clk) if (rnd_or) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input bit f);
    int n = 0;
    bit e = 0, done = 0;
    in_data = IN_W'(d); in_first = f; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    if (f) begin
      e = in_frame; in_frame = 1; m_sum = d; m_cnt = 1;
    end else if (!in_frame) e = 1;
    else begin
      m_sum += d; m_cnt++;
      if (m_cnt == N_CH) begin exp_q.push_back(m_sum); done = 1; in_frame = 0; m_cnt = 0; end
    end
    err_exp += int'(e);
    @(posedge clk); #1;
    in_valid = 0;
    chk("ch_idx", int'(ch_idx), m_cnt);
    chk("frame_err", int'(frame_err), int'(e));
    chk("busy", int'(busy), int'(in_frame || done));
    if (done) chk("latency_valid", int'(out_valid), 1);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_in_ready"}, int'(in_ready), 1);
    chk({nm, "_ch_idx"}, int'(ch_idx), 0);
    chk({nm, "_out_sum"}, int'(out_sum), 0);
    chk({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_frame_err"}, int'(frame_err), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_vals("rst");
    @(negedge clk) rst_n = 1;
    idle(1);
    for (int i = 1; i <= N_CH; i++) send(i, i == 1);
    idle(1);
    chk("one_cycle_valid", int'(out_valid), 0);
    for (int i = 0; i < N_CH; i++) send(-262144, i == 0);
    idle(1);
    for (int i = 0; i < N_CH; i++) send(262143, i == 0);
    idle(1);
    out_ready = 0;
    for (int i = 0; i < N_CH; i++) send(i * 3 - 7, i == 0);
    in_data = IN_W'(11); in_first = 1; in_valid = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    send(11, 1);
    for (int i = 1; i < N_CH; i++) send(-i, 0);
    idle(1);
    send(5, 0);
    for (int i = 0; i < 7; i++) send(i + 20, i == 0);
    send(3, 1);
    for (int i = 0; i < N_CH - 1; i++) send(1, 0);
    idle(1);
    for (int i = 0; i < N_CH; i++) begin
      idle($urandom_range(0, 3));
      send((i % 2 == 0) ? 100 : -50, i == 0);
    end
    idle(1);
    rnd_or = 1;
    for (int fr = 0; fr < 4; fr++)
      for (int i = 0; i < N_CH; i++) begin
        idle($urandom_range(0, 2));
        send(int'($urandom_range(0, 524287)) - 262144, i == 0);
      end
    rnd_or = 0;
    idle(1);
    out_ready = 1;
    idle(3);
    for (int i = 0; i < 9; i++) send(7, i == 0);
    #2 rst_n = 0;
    in_frame = 0; m_cnt = 0;
    #1 reset_vals("arst");
    @(negedge clk) rst_n = 1;
    idle(1);
    for (int i = 0; i < N_CH; i++) send(2, i == 0);
    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_err_count", err_seen, err_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
